// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per clock, LSB first, with a single
// carry flip-flop. The per-bit full adder is composed from two half-adder cells.

module ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic s0, c0, s, c1, c_next;

  ha u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .sum(s0), .carry(c0));
  ha u_ha1 (.a(s0),      .b(c),       .sum(s),  .carry(c1));
  assign c_next = c0 | c1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            res   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {s, res[WIDTH-1:1]};
          c    <= c_next;
          // Counter parks at zero on the last bit so it never exceeds WIDTH-1.
          if (cnt == LAST) begin
            cnt       <= '0;
            sum_out   <= {s, res[WIDTH-1:1]};
            carry_out <= c_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {carry,sum} pushed at issue time,
// popped and compared by an independent monitor whenever done is seen.

module tb_serial_adder;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  int errors = 0;
  int checks = 0;
  logic [WIDTH:0] sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .sum_out(sum_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum=%0d carry=%0d expected no done at %0t",
                 sum_out, carry_out, $time);
      end else begin
        logic [WIDTH:0] e;
        e = sb.pop_front();
        chk("result", {23'd0, carry_out, sum_out}, {23'd0, e});
      end
    end
  end

  // Called at a negedge inside an IDLE cycle; returns at a negedge inside the next IDLE cycle.
  // pulse[i] raises start (with junk operands) in busy cycle i; pulse[WIDTH] does so in the done cycle.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH:0] exp, input logic [WIDTH:0] pulse,
                       input bit hold_en, input logic [WIDTH-1:0] hold_val);
    bit busy_ok = 1;
    bit hold_ok = 1;
    sb.push_back(exp);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(WIDTH); i++) begin
      start = pulse[i];
      a_in = pulse[i] ? 8'd99 : ~a;
      b_in = pulse[i] ? 8'd99 : ~b;
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
      if (hold_en && sum_out !== hold_val) hold_ok = 0;
      @(negedge clk);
    end
    chk("busy_window", {31'd0, busy_ok}, 32'd1);
    if (hold_en) chk("sum_hold", {31'd0, hold_ok}, 32'd1);
    start = pulse[WIDTH];
    a_in = 8'd99; b_in = 8'd99;
    chk("done_pulse", {30'd0, done, busy}, 32'd2);
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {21'd0, busy, done, carry_out, sum_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'd3,   8'd5,   9'd8,   '0, 0, '0);
    issue(8'd200, 8'd100, 9'd300, '0, 0, '0);
    issue(8'd255, 8'd1,   9'd256, '0, 0, '0);
    issue(8'd0,   8'd0,   9'd0,   '0, 0, '0);

    // start pulses in the 3rd and 8th busy cycles and the done cycle must be ignored
    issue(8'd10, 8'd20, 9'd30, 9'b1_1000_0100, 0, '0);
    @(negedge clk);
    chk("ignored_start_idle", {30'd0, done, busy}, 32'd0);

    // reset during the 4th busy cycle aborts without a done pulse
    a_in = 8'd170; b_in = 8'd85; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {21'd0, busy, done, carry_out, sum_out}, 32'd0);
    quiet = 1;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) quiet = 0;
    end
    chk("abort_stays_idle", {31'd0, quiet}, 32'd1);
    issue(8'd1, 8'd2, 9'd3, '0, 0, '0);

    // back-to-back; previous result must hold through the next SHIFT phase
    issue(8'd15,  8'd15,  9'd30,  '0, 0, '0);
    issue(8'd128, 8'd128, 9'd256, '0, 1, 8'd30);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
